// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and branch-in-ID hazard detection.
// Optional stall-bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   input  logic              RegDst_i,
   input  logic [2:0]        ALUOp_i,
   input  logic              ALUSrc_i,
   input  logic              RegWrite_i,
   input  logic              Memread_i,
   input  logic              Memwrite_i,
   input  logic              Mem2reg_i,
   input  logic              Branch_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [REG_W-1:0]  rs_i,
   input  logic [REG_W-1:0]  rt_i,
   input  logic [REG_W-1:0]  rd_i,
   input  logic              mem_Memread_i,
   input  logic [REG_W-1:0]  mem_wr_addr_i,
   output logic              RegDst_o,
   output logic [2:0]        ALUOp_o,
   output logic              ALUSrc_o,
   output logic              RegWrite_o,
   output logic              Memread_o,
   output logic              Memwrite_o,
   output logic              Mem2reg_o,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [REG_W-1:0]  rs_o,
   output logic [REG_W-1:0]  rt_o,
   output logic [REG_W-1:0]  rd_o,
   output logic [REG_W-1:0]  wr_addr_o,
   output logic              stall_o,
   output logic              pc_write_o,
   output logic              ifid_write_o
`ifdef IDEX_BUBBLE_CNT_EN
   ,
   output logic [15:0]       bubble_cnt_o
`endif
);

   typedef struct packed {
      logic       reg_dst;
      logic [2:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem2reg;
   } ctrl_t;

   ctrl_t             ctrl_d, ctrl_q;
   logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
   logic [REG_W-1:0]  rs_q, rt_q, rd_q, wr_addr_q;

   logic load_use, br_ex, br_mem, stall;

   assign ctrl_d = {RegDst_i, ALUOp_i, ALUSrc_i, RegWrite_i,
                    Memread_i, Memwrite_i, Mem2reg_i};

   // A branch compares in ID, so it must wait for both an EX writer and a MEM load.
   always_comb begin
      load_use = ctrl_q.mem_read && (rt_q != '0) &&
                 ((rt_q == rs_i) || (rt_q == rt_i));
      br_ex    = ctrl_q.reg_write && (wr_addr_q != '0) &&
                 ((wr_addr_q == rs_i) || (wr_addr_q == rt_i));
      br_mem   = mem_Memread_i && (mem_wr_addr_i != '0) &&
                 ((mem_wr_addr_i == rs_i) || (mem_wr_addr_i == rt_i));
      stall    = load_use || (Branch_i && (br_ex || br_mem));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         wr_addr_q <= '0;
      end else if (!hold_i) begin
         ctrl_q    <= stall ? ctrl_t'('0) : ctrl_d;
         rs_data_q <= rs_data_i;
         rt_data_q <= rt_data_i;
         imm_q     <= imm_i;
         rs_q      <= rs_i;
         rt_q      <= rt_i;
         rd_q      <= rd_i;
         wr_addr_q <= RegDst_i ? rd_i : rt_i;
      end
   end

`ifdef IDEX_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         bubble_cnt_q <= '0;
      else if (stall && !hold_i && (bubble_cnt_q != 16'hFFFF))
         bubble_cnt_q <= bubble_cnt_q + 16'd1;
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

   assign RegDst_o     = ctrl_q.reg_dst;
   assign ALUOp_o      = ctrl_q.alu_op;
   assign ALUSrc_o     = ctrl_q.alu_src;
   assign RegWrite_o   = ctrl_q.reg_write;
   assign Memread_o    = ctrl_q.mem_read;
   assign Memwrite_o   = ctrl_q.mem_write;
   assign Mem2reg_o    = ctrl_q.mem2reg;
   assign rs_data_o    = rs_data_q;
   assign rt_data_o    = rt_data_q;
   assign imm_o        = imm_q;
   assign rs_o         = rs_q;
   assign rt_o         = rt_q;
   assign rd_o         = rd_q;
   assign wr_addr_o    = wr_addr_q;
   assign stall_o      = stall;
   assign pc_write_o   = ~stall;
   assign ifid_write_o = ~stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against an instruction-level model of EX contents.
module tb_id_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        hold_i;
   logic        RegDst_i, ALUSrc_i, RegWrite_i, Memread_i, Memwrite_i, Mem2reg_i, Branch_i;
   logic [2:0]  ALUOp_i;
   logic [31:0] rs_data_i, rt_data_i, imm_i;
   logic [4:0]  rs_i, rt_i, rd_i, mem_wr_addr_i;
   logic        mem_Memread_i;
   logic        RegDst_o, ALUSrc_o, RegWrite_o, Memread_o, Memwrite_o, Mem2reg_o;
   logic [2:0]  ALUOp_o;
   logic [31:0] rs_data_o, rt_data_o, imm_o;
   logic [4:0]  rs_o, rt_o, rd_o, wr_addr_o;
   logic        stall_o, pc_write_o, ifid_write_o;
`ifdef IDEX_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_o;
`endif

   id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
      .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
      .RegWrite_i(RegWrite_i), .Memread_i(Memread_i), .Memwrite_i(Memwrite_i),
      .Mem2reg_i(Mem2reg_i), .Branch_i(Branch_i),
      .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
      .mem_Memread_i(mem_Memread_i), .mem_wr_addr_i(mem_wr_addr_i),
      .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
      .RegWrite_o(RegWrite_o), .Memread_o(Memread_o), .Memwrite_o(Memwrite_o),
      .Mem2reg_o(Mem2reg_o),
      .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
      .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .wr_addr_o(wr_addr_o),
      .stall_o(stall_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o)
`ifdef IDEX_BUBBLE_CNT_EN
      , .bubble_cnt_o(bubble_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   bit run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the instruction currently sitting in EX, as a plain record.
   typedef struct {
      bit        regdst, alusrc, regwrite, memread, memwrite, mem2reg;
      bit [2:0]  aluop;
      bit [31:0] rsd, rtd, imm;
      bit [4:0]  rs, rt, rd, wr;
      bit        dv;
   } ex_t;

   ex_t         m;
   int unsigned m_cnt;

   function automatic bit id_reads(input bit [4:0] r);
      return (r != 0) && (r == rs_i || r == rt_i);
   endfunction

   function automatic bit model_hz(input ex_t e);
      bit lu, br;
      lu = e.memread && id_reads(e.rt);
      br = Branch_i && ((e.regwrite && id_reads(e.wr)) ||
                        (mem_Memread_i && id_reads(mem_wr_addr_i)));
      return lu || br;
   endfunction

   function automatic ex_t from_id();
      ex_t e;
      e.regdst = RegDst_i;   e.aluop = ALUOp_i;   e.alusrc = ALUSrc_i;
      e.regwrite = RegWrite_i; e.memread = Memread_i; e.memwrite = Memwrite_i;
      e.mem2reg = Mem2reg_i;
      e.rsd = rs_data_i; e.rtd = rt_data_i; e.imm = imm_i;
      e.rs = rs_i; e.rt = rt_i; e.rd = rd_i;
      e.wr = RegDst_i ? rd_i : rt_i;
      e.dv = 1;
      return e;
   endfunction

   function automatic ex_t empty_ex(input bit dv);
      ex_t e;
      e = '{default: 0};
      e.dv = dv;
      return e;
   endfunction

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m     <= empty_ex(1);
         m_cnt <= 0;
      end else if (!hold_i) begin
         if (model_hz(m)) begin
            m <= empty_ex(0);
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
         end else begin
            m <= from_id();
         end
      end
   end

   always @(negedge clk_i) begin
      if (run) begin
         chk("stall", stall_o, model_hz(m));
         chk("pc_write", pc_write_o, !model_hz(m));
         chk("ifid_write", ifid_write_o, !model_hz(m));
         chk("ctrl", {RegDst_o, ALUOp_o, ALUSrc_o, RegWrite_o, Memread_o, Memwrite_o, Mem2reg_o},
             {m.regdst, m.aluop, m.alusrc, m.regwrite, m.memread, m.memwrite, m.mem2reg});
         if (m.dv) begin
            chk("rs_data", rs_data_o, m.rsd);
            chk("rt_data", rt_data_o, m.rtd);
            chk("imm", imm_o, m.imm);
            chk("addr", {rs_o, rt_o, rd_o, wr_addr_o}, {m.rs, m.rt, m.rd, m.wr});
         end
`ifdef IDEX_BUBBLE_CNT_EN
         chk("bubble_cnt", bubble_cnt_o, m_cnt);
`endif
      end
   end

   task automatic clear_in();
      hold_i = 0; RegDst_i = 0; ALUOp_i = 0; ALUSrc_i = 0; RegWrite_i = 0;
      Memread_i = 0; Memwrite_i = 0; Mem2reg_i = 0; Branch_i = 0;
      rs_data_i = 0; rt_data_i = 0; imm_i = 0; rs_i = 0; rt_i = 0; rd_i = 0;
      mem_Memread_i = 0; mem_wr_addr_i = 0;
   endtask

   task automatic set_lw(input bit [4:0] rt);
      clear_in();
      Memread_i = 1; RegWrite_i = 1; ALUSrc_i = 1; Mem2reg_i = 1;
      rs_i = 1; rt_i = rt; rt_data_i = 32'hABCD;
   endtask

   task automatic rand_in();
      hold_i = ($urandom_range(0, 9) == 0);
      RegDst_i = 1'($urandom_range(0, 1));  ALUOp_i = 3'($urandom_range(0, 7));
      ALUSrc_i = 1'($urandom_range(0, 1));  RegWrite_i = 1'($urandom_range(0, 1));
      Memread_i = ($urandom_range(0, 9) < 3); Memwrite_i = 1'($urandom_range(0, 1));
      Mem2reg_i = 1'($urandom_range(0, 1)); Branch_i = ($urandom_range(0, 3) == 0);
      rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
      rs_i = 5'($urandom_range(0, 7)); rt_i = 5'($urandom_range(0, 7));
      rd_i = 5'($urandom_range(0, 7));
      mem_Memread_i = ($urandom_range(0, 9) < 3);
      mem_wr_addr_i = 5'($urandom_range(0, 7));
   endtask

   initial begin
      // Reset with nonzero inputs; no branch so nothing can raise a hazard.
      rst_i = 0;
      clear_in();
      RegDst_i = 1; ALUOp_i = 3'b101; RegWrite_i = 1; Memread_i = 1;
      rs_data_i = 32'hDEAD; rt_data_i = 32'hBEEF; imm_i = 32'h1234;
      rs_i = 3; rt_i = 4; rd_i = 5; mem_Memread_i = 1; mem_wr_addr_i = 3;
      @(posedge clk_i); #1 run = 1;
      @(posedge clk_i); #2;
      chk("rst_ctrl", {RegDst_o, ALUOp_o, RegWrite_o, Memread_o}, 0);
      chk("rst_data", rs_data_o | rt_data_o | imm_o, 0);
      chk("rst_addr", {rs_o, rt_o, rd_o, wr_addr_o}, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_pc_write", pc_write_o, 1);
`ifdef IDEX_BUBBLE_CNT_EN
      chk("rst_cnt", bubble_cnt_o, 0);
`endif

      // R-type pass-through
      #1 rst_i = 1;
      clear_in();
      RegDst_i = 1; ALUOp_i = 3'b111; RegWrite_i = 1;
      rs_data_i = 32'h5; rt_data_i = 32'h7; rt_i = 2; rd_i = 3;
      @(posedge clk_i); #2;
      chk("rtype_aluop", ALUOp_o, 3'b111);
      chk("rtype_wr", wr_addr_o, 3);
      chk("rtype_rsd", rs_data_o, 32'h5);
      chk("rtype_rtd", rt_data_o, 32'h7);

      // Load-use
      #1 set_lw(4);
      @(posedge clk_i); #1;
      clear_in(); RegDst_i = 1; RegWrite_i = 1; ALUOp_i = 3'b010; rs_i = 4; rt_i = 5; rd_i = 6;
      #1;
      chk("lu_stall", stall_o, 1);
      chk("lu_pc_write", pc_write_o, 0);
      @(posedge clk_i); #2;
      chk("lu_bubble", {RegDst_o, ALUOp_o, ALUSrc_o, RegWrite_o, Memread_o, Memwrite_o, Mem2reg_o}, 0);
      chk("lu_cleared", stall_o, 0);
`ifdef IDEX_BUBBLE_CNT_EN
      chk("lu_cnt", bubble_cnt_o, 1);
`endif

      // lw to $0 never stalls
      #1 set_lw(0); rs_i = 0;
      @(posedge clk_i); #1;
      clear_in(); RegDst_i = 1; RegWrite_i = 1; rs_i = 0; rt_i = 0; rd_i = 2;
      #1 chk("zero_no_stall", stall_o, 0);

      // Branch behind load: two stall cycles
      @(posedge clk_i); #1 set_lw(8);
      @(posedge clk_i); #1;
      clear_in(); Branch_i = 1; rs_i = 8; rt_i = 9;
      #1 chk("br_stall1", stall_o, 1);
      @(posedge clk_i); #1;
      mem_Memread_i = 1; mem_wr_addr_i = 8;
      #1 chk("br_stall2", stall_o, 1);
      @(posedge clk_i); #1;
      mem_Memread_i = 0;
      #1 chk("br_stall3", stall_o, 0);

      // Hold with a pending load-use
      @(posedge clk_i); #1 set_lw(4);
      @(posedge clk_i); #1;
      clear_in(); RegWrite_i = 1; rs_i = 4; hold_i = 1;
      #1 chk("hold_stall", stall_o, 1);
      for (int k = 0; k < 3; k++) begin
         rs_data_i = $urandom; rt_data_i = $urandom; ALUOp_i = 3'($urandom_range(0, 7));
         @(posedge clk_i); #2;
         chk("hold_memread", Memread_o, 1);
         chk("hold_rt", rt_o, 4);
         chk("hold_rtd", rt_data_o, 32'hABCD);
`ifdef IDEX_BUBBLE_CNT_EN
         chk("hold_cnt", bubble_cnt_o, 3);
`endif
      end
      hold_i = 0;
      @(posedge clk_i); #2;
      chk("unhold_memread", Memread_o, 0);
`ifdef IDEX_BUBBLE_CNT_EN
      chk("unhold_cnt", bubble_cnt_o, 4);
`endif

      // Random traffic with occasional asynchronous reset pulses
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk_i); #1;
         rst_i = 1;
         rand_in();
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_i = 0;
         end
      end
      @(posedge clk_i); #1 rst_i = 1;
      repeat (2) @(posedge clk_i);
      #6;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
